// File: rtl/traffic_seq.sv
// traffic_seq: table-driven traffic-light phase sequencer. It holds N_PHASE
// entries {man, blink, on, dur}, which a ready/valid command port can write, insert or delete.
module traffic_seq #(
  parameter int N_PHASE   = 16,
  parameter int IDX_W     = $clog2(N_PHASE),
  parameter int N_LIGHT   = 10,
  parameter int DUR_W     = 6,
  parameter int SEC_DIV   = 50_000_000,
  parameter int BLINK_DIV = 6_250_000,
  parameter int DEF_DUR   = 15
) (
  input  logic                        clksrc1_1,
  input  logic                        reset,
  input  logic                        stop,
  input  logic                        next_pulse,
  input  logic                        plus_pulse,
  input  logic                        minus_pulse,
  input  logic                        cmd_valid,
  input  logic [1:0]                  cmd_op,
  input  logic [IDX_W-1:0]            cmd_idx,
  input  logic [2*N_LIGHT+DUR_W:0]    cmd_data,
  output logic                        cmd_ready,
  output logic                        cmd_err,
  output logic [N_LIGHT-1:0]          lights,
  output logic                        greenman,
  output logic [IDX_W-1:0]            phase,
  output logic [DUR_W-1:0]            remaining,
  output logic [IDX_W:0]              phase_cnt
);

  localparam int ENT_W = 1 + 2*N_LIGHT + DUR_W;
  localparam int CNT_W = IDX_W + 1;
  localparam int SEC_W = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ENT_W-1:0] DEF_ENT = ENT_W'(DEF_DUR);
  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_INS = 2'b01;
  localparam logic [1:0] OP_DEL = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT_UP = 2'd1, SHIFT_DN = 2'd2} state_t;

  function automatic logic [DUR_W-1:0] dur_of(input logic [ENT_W-1:0] e);
    return e[DUR_W-1:0];
  endfunction

  function automatic logic [N_LIGHT-1:0] on_of(input logic [ENT_W-1:0] e);
    return e[DUR_W +: N_LIGHT];
  endfunction

  function automatic logic [N_LIGHT-1:0] blink_of(input logic [ENT_W-1:0] e);
    return e[DUR_W+N_LIGHT +: N_LIGHT];
  endfunction

  function automatic logic man_of(input logic [ENT_W-1:0] e);
    return e[ENT_W-1];
  endfunction

  // A stored duration of zero still runs for one tick.
  function automatic logic [DUR_W-1:0] reload_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1'b1) : d;
  endfunction

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   tbl_q [N_PHASE];
  logic [ENT_W-1:0]   tbl_d [N_PHASE];
  logic [IDX_W-1:0]   phase_q, phase_d, k_q, k_d, sidx_q, sidx_d;
  logic [DUR_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic               flash_q, flash_d, man_q, man_d, ready_q, ready_d, err_q, err_d;
  logic               tpend_q, tpend_d, npend_q, npend_d;
  logic [N_LIGHT-1:0] lights_q, lights_d;
  logic [ENT_W-1:0]   sdata_q, sdata_d;

  logic               tick_s, blk_term_s, do_tick_s, do_next_s, adv_s;
  logic [IDX_W-1:0]   last_s, nphase_s;
  logic [ENT_W-1:0]   cur_s;
  logic [DUR_W-1:0]   cur_dur_s, new_dur_s;

  assign tick_s     = (sec_q == SEC_W'(SEC_DIV - 1));
  assign blk_term_s = (blk_q == BLK_W'(BLINK_DIV - 1));
  assign last_s     = IDX_W'(cnt_q - CNT_W'(1'b1));
  assign nphase_s   = (phase_q == last_s) ? '0 : phase_q + IDX_W'(1'b1);
  assign cur_s      = tbl_q[phase_q];
  assign cur_dur_s  = dur_of(cur_s);
  assign do_tick_s  = tick_s | tpend_q;
  assign do_next_s  = next_pulse | npend_q;
  assign adv_s      = do_next_s | (do_tick_s & ~stop & (rem_q <= DUR_W'(1'b1)));

  // State register with synchronous reset; reset also aborts any shift in flight.
  always_ff @(posedge clksrc1_1) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < N_PHASE; i++) tbl_q[i] <= (i == 0) ? DEF_ENT : '0;
      phase_q  <= '0;
      rem_q    <= DUR_W'(DEF_DUR);
      cnt_q    <= CNT_W'(1'b1);
      sec_q    <= '0;
      blk_q    <= '0;
      flash_q  <= 1'b0;
      man_q    <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
      tpend_q  <= 1'b0;
      npend_q  <= 1'b0;
      lights_q <= '0;
      k_q      <= '0;
      sidx_q   <= '0;
      sdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      tbl_q    <= tbl_d;
      phase_q  <= phase_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      sec_q    <= sec_d;
      blk_q    <= blk_d;
      flash_q  <= flash_d;
      man_q    <= man_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      tpend_q  <= tpend_d;
      npend_q  <= npend_d;
      lights_q <= lights_d;
      k_q      <= k_d;
      sidx_q   <= sidx_d;
      sdata_q  <= sdata_d;
    end
  end

  // Next-state: prescalers, countdown/advance, duration trim and command FSM.
  always_comb begin
    state_d   = state_q;
    tbl_d     = tbl_q;
    phase_d   = phase_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    sidx_d    = sidx_q;
    sdata_d   = sdata_q;
    tpend_d   = tpend_q;
    npend_d   = npend_q;
    err_d     = 1'b0;
    new_dur_s = cur_dur_s;
    sec_d     = tick_s ? '0 : sec_q + SEC_W'(1'b1);
    blk_d     = blk_term_s ? '0 : blk_q + BLK_W'(1'b1);
    flash_d   = flash_q ^ blk_term_s;
    lights_d  = on_of(cur_s) & ~(blink_of(cur_s) & {N_LIGHT{flash_q}});
    man_d     = man_of(cur_s);

    case (state_q)
      IDLE: begin
        tpend_d = 1'b0;
        npend_d = 1'b0;
        if (adv_s) begin
          phase_d = nphase_s;
          rem_d   = reload_dur(dur_of(tbl_q[nphase_s]));
        end else if (do_tick_s && !stop) begin
          rem_d = rem_q - DUR_W'(1'b1);
        end else begin
          rem_d = rem_q;
        end

        if (plus_pulse && !minus_pulse) begin
          new_dur_s = (cur_dur_s == '1) ? cur_dur_s : cur_dur_s + DUR_W'(1'b1);
        end else if (minus_pulse && !plus_pulse) begin
          new_dur_s = (cur_dur_s > DUR_W'(1'b1)) ? cur_dur_s - DUR_W'(1'b1) : cur_dur_s;
        end else begin
          new_dur_s = cur_dur_s;
        end
        if (plus_pulse ^ minus_pulse) begin
          tbl_d[phase_q][DUR_W-1:0] = new_dur_s;
          if (!adv_s && (rem_d > reload_dur(new_dur_s))) rem_d = reload_dur(new_dur_s);
          else rem_d = rem_d;
        end else begin
          tbl_d[phase_q] = tbl_d[phase_q];
        end

        if (cmd_valid) begin
          case (cmd_op)
            OP_WR: begin
              if ({1'b0, cmd_idx} < cnt_q) tbl_d[cmd_idx] = cmd_data;
              else err_d = 1'b1;
            end
            OP_INS: begin
              if (({1'b0, cmd_idx} <= cnt_q) && (cnt_q < CNT_W'(N_PHASE))) begin
                state_d = SHIFT_UP;
                k_d     = IDX_W'(cnt_q);
                sidx_d  = cmd_idx;
                sdata_d = cmd_data;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_DEL: begin
              if (({1'b0, cmd_idx} < cnt_q) && (cnt_q > CNT_W'(1'b1))) begin
                state_d = SHIFT_DN;
                k_d     = cmd_idx;
                sidx_d  = cmd_idx;
              end else begin
                err_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end else begin
          err_d = 1'b0;
        end
      end

      SHIFT_UP: begin
        tpend_d = tpend_q | tick_s;
        npend_d = npend_q | next_pulse;
        if (k_q != sidx_q) begin
          tbl_d[k_q] = tbl_q[k_q - IDX_W'(1'b1)];
          k_d        = k_q - IDX_W'(1'b1);
        end else begin
          tbl_d[sidx_q] = sdata_q;
          cnt_d         = cnt_q + CNT_W'(1'b1);
          state_d       = IDLE;
          // Keep the running entry running after it moves up one slot.
          if (sidx_q <= phase_q) phase_d = phase_q + IDX_W'(1'b1);
          else phase_d = phase_q;
        end
      end

      SHIFT_DN: begin
        tpend_d = tpend_q | tick_s;
        npend_d = npend_q | next_pulse;
        if (k_q != last_s) begin
          tbl_d[k_q] = tbl_q[k_q + IDX_W'(1'b1)];
          k_d        = k_q + IDX_W'(1'b1);
        end else begin
          tbl_d[last_s] = '0;
          cnt_d         = cnt_q - CNT_W'(1'b1);
          state_d       = IDLE;
          if (sidx_q < phase_q) begin
            phase_d = phase_q - IDX_W'(1'b1);
          end else if ((sidx_q == phase_q) && (sidx_q == last_s)) begin
            phase_d = '0;
            rem_d   = reload_dur(dur_of(tbl_q[0]));
          end else if (sidx_q == phase_q) begin
            rem_d = reload_dur(dur_of(tbl_q[sidx_q]));
          end else begin
            phase_d = phase_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  assign cmd_ready = ready_q;
  assign cmd_err   = err_q;
  assign lights    = lights_q;
  assign greenman  = man_q;
  assign phase     = phase_q;
  assign remaining = rem_q;
  assign phase_cnt = cnt_q;

endmodule

// File: tb/tb_traffic_seq.sv
// tb_traffic_seq: directed bench for traffic_seq with SEC_DIV=4 and BLINK_DIV=2.
// It uses hand-computed expectations, and cyc counts clock edges since the last reset release.
module tb_traffic_seq;

  localparam int IDX_W   = 4;
  localparam int N_LIGHT = 10;
  localparam int DUR_W   = 6;
  localparam int ENT_W   = 1 + 2*N_LIGHT + DUR_W;

  logic               clk = 1'b0;
  logic               reset, stop, next_pulse, plus_pulse, minus_pulse, cmd_valid;
  logic [1:0]         cmd_op;
  logic [IDX_W-1:0]   cmd_idx;
  logic [ENT_W-1:0]   cmd_data;
  logic               cmd_ready, cmd_err, greenman;
  logic [N_LIGHT-1:0] lights;
  logic [IDX_W-1:0]   phase;
  logic [DUR_W-1:0]   remaining;
  logic [IDX_W:0]     phase_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n;
  logic [N_LIGHT-1:0] exp_l;

  traffic_seq #(
    .N_PHASE(16), .N_LIGHT(N_LIGHT), .DUR_W(DUR_W),
    .SEC_DIV(4), .BLINK_DIV(2), .DEF_DUR(15)
  ) dut (
    .clksrc1_1(clk), .reset(reset), .stop(stop), .next_pulse(next_pulse),
    .plus_pulse(plus_pulse), .minus_pulse(minus_pulse), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .cmd_err(cmd_err), .lights(lights), .greenman(greenman), .phase(phase),
    .remaining(remaining), .phase_cnt(phase_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int cnt = 1);
    repeat (cnt) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  function automatic logic [ENT_W-1:0] ent(input logic man, input logic [N_LIGHT-1:0] blink,
                                           input logic [N_LIGHT-1:0] on, input logic [DUR_W-1:0] dur);
    return {man, blink, on, dur};
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [IDX_W-1:0] idx, input logic [ENT_W-1:0] data);
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_data = data;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse(input logic nx, input logic pl, input logic mi);
    next_pulse = nx; plus_pulse = pl; minus_pulse = mi;
    step(1);
    next_pulse = 1'b0; plus_pulse = 1'b0; minus_pulse = 1'b0;
  endtask

  task automatic wait_phase(input logic [IDX_W-1:0] target, input string tag, output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (phase !== target && cnt < 200);
    check_eq({tag, "_reached"}, phase, target);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; stop = 1'b0; next_pulse = 1'b0; plus_pulse = 1'b0; minus_pulse = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_idx = '0; cmd_data = '0;
    step(3);
    reset = 1'b0;
    cyc = 0;

    // reset state
    check_eq("rst_phase", phase, 0);
    check_eq("rst_rem", remaining, 15);
    check_eq("rst_lights", lights, 0);
    check_eq("rst_man", greenman, 0);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_err", cmd_err, 0);
    check_eq("rst_cnt", phase_cnt, 1);

    // free-running countdown of the single default phase
    step(3);  check_eq("cd_rem15", remaining, 15);
    step(1);  check_eq("cd_rem14", remaining, 14);
    step(55); check_eq("cd_rem1", remaining, 1);
    step(1);  check_eq("cd_reload", remaining, 15);
    check_eq("cd_phase", phase, 0);

    // two inserts, second with a tick landing on its busy cycle
    send_cmd(2'b01, 4'd1, ent(1'b0, '0, '0, 6'd2));
    check_eq("ins1_busy", cmd_ready, 0);
    step(1);
    check_eq("ins1_ready", cmd_ready, 1);
    check_eq("ins1_cnt", phase_cnt, 2);
    send_cmd(2'b01, 4'd2, ent(1'b0, '0, '0, 6'd3));
    check_eq("ins2_busy", cmd_ready, 0);
    step(1);
    check_eq("ins2_ready", cmd_ready, 1);
    check_eq("ins2_cnt", phase_cnt, 3);
    check_eq("ins2_rem_held", remaining, 15);
    step(1);
    check_eq("ins2_pend_tick", remaining, 14);

    wait_phase(4'd1, "seq_p1", n);
    check_eq("seq_p0_cycles", n, 55);
    check_eq("seq_p1_rem", remaining, 2);
    wait_phase(4'd2, "seq_p2", n);
    check_eq("seq_p1_cycles", n, 8);
    check_eq("seq_p2_rem", remaining, 3);
    wait_phase(4'd0, "seq_p0", n);
    check_eq("seq_p2_cycles", n, 12);
    check_eq("seq_p0_rem", remaining, 15);

    // stop freezes the countdown; next_pulse still advances, exactly once with a tick
    stop = 1'b1;
    step(8);
    check_eq("stop_rem", remaining, 15);
    check_eq("stop_phase", phase, 0);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("stop_next_phase", phase, 1);
    check_eq("stop_next_rem", remaining, 2);
    step(4);
    check_eq("stop_frozen", remaining, 2);
    stop = 1'b0;
    step(2);
    check_eq("pre_coinc_rem", remaining, 2);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("coinc_phase", phase, 2);
    check_eq("coinc_rem", remaining, 3);

    // plus/minus saturation and remaining clamp
    stop = 1'b1;
    send_cmd(2'b00, 4'd2, ent(1'b1, '0, '0, 6'd63));
    check_eq("wr_no_reload", remaining, 3);
    check_eq("wr_cnt", phase_cnt, 3);
    pulse(1'b0, 1'b1, 1'b0);
    check_eq("wr_man", greenman, 1);
    send_cmd(2'b00, 4'd1, ent(1'b0, '0, '0, 6'd1));
    send_cmd(2'b00, 4'd0, ent(1'b0, '0, '0, 6'd5));
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("d5_rem", remaining, 5);
    pulse(1'b0, 1'b0, 1'b1);
    check_eq("minus_clamp", remaining, 4);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("d1_rem", remaining, 1);
    pulse(1'b0, 1'b0, 1'b1);
    check_eq("minus_sat1", remaining, 1);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("plus_sat63", remaining, 63);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("minus_stored", remaining, 4);
    pulse(1'b0, 1'b1, 1'b1);
    check_eq("both_rem", remaining, 4);
    repeat (3) pulse(1'b1, 1'b0, 1'b0);
    check_eq("both_no_change", remaining, 4);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("pre_del_phase", phase, 1);

    // delete the running entry with a tick during the shift
    while (cyc % 4 != 1) step(1);
    stop = 1'b0;
    send_cmd(2'b10, 4'd1, '0);
    check_eq("del_busy", cmd_ready, 0);
    step(2);
    check_eq("del_ready", cmd_ready, 1);
    check_eq("del_cnt", phase_cnt, 2);
    check_eq("del_phase", phase, 1);
    check_eq("del_reload", remaining, 63);
    step(1);
    check_eq("del_pend_tick", remaining, 62);
    check_eq("del_man", greenman, 1);

    // delete of the last entry while running it, then illegal commands
    stop = 1'b1;
    send_cmd(2'b10, 4'd1, '0);
    check_eq("dlast_busy", cmd_ready, 0);
    step(1);
    check_eq("dlast_ready", cmd_ready, 1);
    check_eq("dlast_cnt", phase_cnt, 1);
    check_eq("dlast_phase", phase, 0);
    check_eq("dlast_rem", remaining, 4);
    send_cmd(2'b10, 4'd0, '0);
    check_eq("del1_err", cmd_err, 1);
    check_eq("del1_ready", cmd_ready, 1);
    step(1);
    check_eq("del1_err_clr", cmd_err, 0);
    check_eq("del1_cnt", phase_cnt, 1);
    send_cmd(2'b11, 4'd0, ent(1'b1, '1, '1, 6'd7));
    check_eq("op3_err", cmd_err, 1);
    check_eq("op3_cnt", phase_cnt, 1);
    check_eq("op3_rem", remaining, 4);

    // flashing lamp 0
    send_cmd(2'b00, 4'd0, ent(1'b0, 10'h001, 10'h001, 6'd4));
    step(2);
    for (int i = 0; i < 6; i++) begin
      step(1);
      exp_l = '0;
      exp_l[0] = ((((cyc - 1) / 2) % 2) == 0);
      check_eq("blink_lights", lights, exp_l);
    end

    // reset in the middle of an insert
    send_cmd(2'b01, 4'd0, ent(1'b1, '0, 10'h3ff, 6'd9));
    check_eq("rins_busy", cmd_ready, 0);
    reset = 1'b1;
    step(1);
    check_eq("rins_lights", lights, 0);
    check_eq("rins_cnt", phase_cnt, 1);
    check_eq("rins_ready", cmd_ready, 1);
    check_eq("rins_phase", phase, 0);
    check_eq("rins_rem", remaining, 15);
    reset = 1'b0;
    cyc = 0;
    step(1);
    check_eq("rins_cnt_after", phase_cnt, 1);
    check_eq("rins_ready_after", cmd_ready, 1);
    check_eq("rins_man_after", greenman, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_seq.md
# traffic_seq

Parametrised successor to the fixed ten-phase traffic controller: a table-driven phase sequencer with N_PHASE entries, N_LIGHT lamp outputs, per-lamp steady or flashing mode, and a pedestrian (greenman) flag. It sits between the debounced, one-shot button logic and the lamp, greenman and 7-segment drivers. It replaces the per-millisecond countdown and the ad-hoc edit/delete logic with a single clock domain and a command port with ready/valid handshaking. Insert and delete are performed as multi-cycle table shifts.

## Interface
- N_PHASE, 16, table depth; IDX_W = clog2(N_PHASE)
- N_LIGHT, 10, lamp count
- DUR_W, 6, duration width in seconds
- SEC_DIV, 50_000_000, clock cycles per second tick
- BLINK_DIV, 6_250_000, clock cycles per flash half-period
- DEF_DUR, 15, duration of entry 0 after reset
- clksrc1_1  in  1  clock
- reset  in  1  synchronous, active-high
- stop  in  1  level; 1 freezes the countdown
- next_pulse  in  1  one-cycle pulse; advance the phase now
- plus_pulse, minus_pulse  in  1  one-cycle pulses; adjust the current phase's duration
- cmd_valid  in  1  command request
- cmd_op  in  2  00 write, 01 insert, 10 delete, 11 reserved (error)
- cmd_idx  in  IDX_W  target entry
- cmd_data  in  1+2*N_LIGHT+DUR_W  {man, blink[N_LIGHT], on[N_LIGHT], dur}
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_err  out  1  one-cycle pulse when a command is dropped
- lights  out  N_LIGHT  registered lamp drive
- greenman  out  1  man bit of the current entry
- phase  out  IDX_W  current entry index
- remaining  out  DUR_W  seconds left in the current phase
- phase_cnt  out  IDX_W+1  number of valid entries, 1..N_PHASE

## Operation
- Reset state:
  - phase_cnt=1; entry 0 = {0, 0, 0, DEF_DUR}; all other entries cleared.
  - phase=0, remaining=DEF_DUR, lights=0, greenman=0, cmd_ready=1, cmd_err=0.
  - Prescalers and the flash phase cleared.
  - Reset during a shift aborts the shift.
- Prescalers:
  - sec_cnt runs 0..SEC_DIV-1 and emits `tick` on its terminal cycle.
  - blink_cnt toggles `flash` every BLINK_DIV cycles.
- Countdown, on tick with stop=0:
  - If remaining>1, decrement remaining.
  - Otherwise advance.
- Advance:
  - phase = (phase==phase_cnt-1) ? 0 : phase+1.
  - remaining = max(dur[new phase], 1). A stored dur of 0 is treated as 1.
- next_pulse advances regardless of stop. next_pulse and tick in the same cycle produce exactly one advance.
- Lights: lights <= on & ~(blink & {N_LIGHT{flash}}); greenman <= man. Both come from the entry at the current phase.
- Plus/minus:
  - Act on dur[phase], saturating at 2^DUR_W-1 and at 1.
  - Both pulses in the same cycle: no change.
  - If remaining exceeds the new dur, remaining is clamped to it.
- Command FSM states: IDLE, SHIFT_UP, SHIFT_DN.
  - Write (idx<phase_cnt): single cycle; cmd_ready stays 1. If idx==phase, remaining is not reloaded.
  - Insert (idx<=phase_cnt, phase_cnt<N_PHASE):
    - SHIFT_UP moves entry k-1→k for k=phase_cnt down to idx+1, one entry per cycle.
    - It then writes cmd_data at idx and increments phase_cnt.
    - If idx<=phase, phase increments so the same entry keeps running.
  - Delete (idx<phase_cnt, phase_cnt>1):
    - SHIFT_DN moves entry k+1→k for k=idx up to phase_cnt-2, one entry per cycle. phase_cnt then decrements.
    - idx<phase: phase decrements.
    - idx==phase: phase stays at idx (0 if idx was the last entry) and remaining reloads from the new entry.
  - Out-of-range index, insert when full, delete when phase_cnt==1, or op 11: the command is accepted, no state changes, and cmd_err pulses.
- While busy (SHIFT_*):
  - tick and next_pulse each set a one-deep sticky pending flag. The flag is applied on the first cycle in IDLE.
  - plus/minus pulses are dropped.

## Timing
- All outputs are registered, with 1-cycle latency from the causing event.
- cmd_ready falls the cycle after an insert or delete is accepted.
- Busy cycles:
  - Insert: phase_cnt-idx shift cycles plus 1 write cycle.
  - Delete: phase_cnt-1-idx shift cycles plus 1 update cycle. It completes in 1 cycle when idx is the last entry.
- cmd_ready returns to 1 on the cycle phase_cnt updates.
- cmd_err is asserted on the cycle after acceptance.
- A phase of duration D lasts exactly D ticks.

## Test plan
- Reset, SEC_DIV=4, no commands: remaining counts 15..1, then phase holds 0 (phase_cnt=1) and remaining reloads to 15 every 60 cycles.
- Write entries 1,2 via insert at idx 1 and 2 with dur 2 and 3: cmd_ready is low for 1 cycle each, phase_cnt=3, and the sequence is 0→1→2→0 with phase lengths 15/2/3 ticks.
- stop=1 with next_pulse: remaining freezes and phase advances once. next_pulse coincident with tick also advances exactly once.
- plus at dur=63 stays 63; minus at dur=1 stays 1; minus while remaining=5 and dur=5 gives dur=4 and remaining=4.
- Delete idx=phase=1 of 3 with a tick arriving during the shift: phase stays 1 showing the former entry 2, phase_cnt=2, and the pending tick applies after ready returns. A delete with phase_cnt=1 gives a cmd_err pulse and no change.
- Entry with on=blink=0x001, BLINK_DIV=2: lights[0] toggles every 2 cycles. Reset asserted mid-insert: lights=0, phase_cnt=1, cmd_ready=1 on the next cycle.
